// File: rtl/n_channel_stream_multiplexer_if.sv
// n_channel_stream_multiplexer_if: channel-side and consumer-side stream signals of the N-to-1 mux.
interface n_channel_stream_multiplexer_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8
);
    localparam int SEL_W = $clog2(N_CH);
    logic [SEL_W-1:0]       sel;
    logic [N_CH-1:0]        in_valid;
    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_last;
    logic [N_CH-1:0]        in_ready;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_data;
    logic                   out_last;
    logic [SEL_W-1:0]       out_ch;
    logic                   out_ready;
    modport master (
        output sel, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_ch
    );
    modport slave (
        input  sel, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_ch
    );
endinterface

// File: rtl/n_channel_stream_multiplexer.sv
// n_channel_stream_multiplexer: N-to-1 valid/ready mux, fixed select (MODE 0) or round-robin (MODE 1), registered output.
// Define MUX_LAST_LOCK_EN to hold the grant on one channel from its first beat until its in_last beat.
module n_channel_stream_multiplexer #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int MODE   = 0
) (
    input logic clk,
    input logic rst,
    n_channel_stream_multiplexer_if.slave bus
);
    localparam int SEL_W = $clog2(N_CH);
    logic [SEL_W-1:0]  ptr_q, ptr_d, rr_g, base_g, grant, ch_q, ch_d;
    logic [SEL_W:0]    off, sum;
    logic [N_CH-1:0]   rot;
    logic              base_ok, grant_ok, can_accept, xfer, adv;
    logic              valid_q, valid_d, last_q, last_d;
    logic [DATA_W-1:0] data_q, data_d;
    // Rotate valids so bit 0 is the pointer's channel, then take the lowest set bit.
    always_comb begin
        rot = N_CH'({bus.in_valid, bus.in_valid} >> ptr_q);
        off = '0;
        for (int j = N_CH - 1; j >= 0; j--) off = rot[j] ? (SEL_W+1)'(j) : off;
        sum = {1'b0, ptr_q} + off;
        rr_g = SEL_W'(int'(sum) >= N_CH ? int'(sum) - N_CH : int'(sum));
    end
    assign base_g     = MODE == 1 ? rr_g : bus.sel;
    assign base_ok    = MODE == 1 ? |bus.in_valid : int'(bus.sel) < N_CH;
    assign can_accept = !valid_q | bus.out_ready;
    assign bus.in_ready = (!rst && can_accept && grant_ok) ? N_CH'(1) << grant : '0;
    assign xfer       = |(bus.in_valid & bus.in_ready);
`ifdef MUX_LAST_LOCK_EN
    logic             lock_q, lock_d;
    logic [SEL_W-1:0] lch_q, lch_d;
    assign grant    = lock_q ? lch_q : base_g;
    assign grant_ok = lock_q | base_ok;
    assign adv      = xfer & bus.in_last[grant];
    assign lock_d   = xfer ? !bus.in_last[grant] : lock_q;
    assign lch_d    = xfer ? grant : lch_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= 1'b0;
            lch_q  <= '0;
        end else begin
            lock_q <= lock_d;
            lch_q  <= lch_d;
        end
    end
`else
    assign grant    = base_g;
    assign grant_ok = base_ok;
    assign adv      = xfer;
`endif
    always_comb begin
        valid_d = xfer | (valid_q & !bus.out_ready);
        data_d  = xfer ? bus.in_data[int'(grant)*DATA_W +: DATA_W] : data_q;
        last_d  = xfer ? bus.in_last[grant] : last_q;
        ch_d    = xfer ? grant : ch_q;
        ptr_d   = (MODE == 1 && adv) ? (grant == SEL_W'(N_CH - 1) ? '0 : grant + 1'b1) : ptr_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_last  = last_q;
    assign bus.out_ch    = ch_q;
endmodule

// File: tb/tb_n_channel_stream_multiplexer.sv
// tb_n_channel_stream_multiplexer: three mux builds (4ch fixed, 4ch round-robin, 5ch fixed) against a queue-free behavioural model.
module tb_n_channel_stream_multiplexer;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  v, lst;
    logic [39:0] dat;
    logic [2:0]  sel;
    logic        ordy;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    n_channel_stream_multiplexer_if #(.N_CH(4), .DATA_W(8)) if0 ();
    n_channel_stream_multiplexer_if #(.N_CH(4), .DATA_W(8)) if1 ();
    n_channel_stream_multiplexer_if #(.N_CH(5), .DATA_W(8)) if5 ();
    n_channel_stream_multiplexer #(.N_CH(4), .DATA_W(8), .MODE(0)) d0 (.clk(clk), .rst(rst), .bus(if0));
    n_channel_stream_multiplexer #(.N_CH(4), .DATA_W(8), .MODE(1)) d1 (.clk(clk), .rst(rst), .bus(if1));
    n_channel_stream_multiplexer #(.N_CH(5), .DATA_W(8), .MODE(0)) d5 (.clk(clk), .rst(rst), .bus(if5));

    assign if0.sel = sel[1:0];
    assign if0.in_valid = v[3:0];
    assign if0.in_data = dat[31:0];
    assign if0.in_last = lst[3:0];
    assign if0.out_ready = ordy;
    assign if1.sel = sel[1:0];
    assign if1.in_valid = v[3:0];
    assign if1.in_data = dat[31:0];
    assign if1.in_last = lst[3:0];
    assign if1.out_ready = ordy;
    assign if5.sel = sel;
    assign if5.in_valid = v;
    assign if5.in_data = dat;
    assign if5.in_last = lst;
    assign if5.out_ready = ordy;

    int a_ov[3], a_od[3], a_ol[3], a_ch[3], a_rdy[3];
    assign a_ov[0] = int'(if0.out_valid);
    assign a_od[0] = int'(if0.out_data);
    assign a_ol[0] = int'(if0.out_last);
    assign a_ch[0] = int'(if0.out_ch);
    assign a_rdy[0] = int'(if0.in_ready);
    assign a_ov[1] = int'(if1.out_valid);
    assign a_od[1] = int'(if1.out_data);
    assign a_ol[1] = int'(if1.out_last);
    assign a_ch[1] = int'(if1.out_ch);
    assign a_rdy[1] = int'(if1.in_ready);
    assign a_ov[2] = int'(if5.out_valid);
    assign a_od[2] = int'(if5.out_data);
    assign a_ol[2] = int'(if5.out_last);
    assign a_ch[2] = int'(if5.out_ch);
    assign a_rdy[2] = int'(if5.in_ready);

    typedef struct packed {
        int n; int mode; bit ov; int od; bit ol; int och; int ptr; bit lk; int lch;
    } mst_t;
    mst_t m[3];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Which channel may transfer this cycle, as a one-hot mask.
    function automatic int exp_ready(mst_t s, int vv, int ss, bit orr, bit r);
        if (r || (s.ov && !orr)) return 0;
        if (s.lk) return 1 << s.lch;
        if (s.mode == 0) return ss < s.n ? 1 << ss : 0;
        for (int k = 0; k < s.n; k++)
            if (vv[(s.ptr + k) % s.n]) return 1 << ((s.ptr + k) % s.n);
        return 0;
    endfunction

    function automatic mst_t step(mst_t s, int vv, int ss, bit orr, bit r, logic [39:0] d, logic [4:0] l);
        int x, g;
        x = exp_ready(s, vv, ss, orr, r) & vv;
        if (r) return '{n: s.n, mode: s.mode, default: 0};
        if (x == 0) begin
            if (orr) s.ov = 1'b0;
            return s;
        end
        g = 0;
        for (int k = 0; k < s.n; k++) if (x[k]) g = k;
        s.ov = 1'b1;
        s.od = int'(d[g*8 +: 8]);
        s.ol = l[g];
        s.och = g;
`ifdef MUX_LAST_LOCK_EN
        s.lk = !l[g];
        s.lch = g;
        if (l[g]) s.ptr = (g + 1) % s.n;
`else
        s.ptr = (g + 1) % s.n;
`endif
        return s;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_out_valid", i), a_ov[i], int'(m[i].ov));
            chk($sformatf("d%0d_out_data", i), a_od[i], m[i].od);
            chk($sformatf("d%0d_out_last", i), a_ol[i], int'(m[i].ol));
            chk($sformatf("d%0d_out_ch", i), a_ch[i], m[i].och);
            chk($sformatf("d%0d_in_ready", i), a_rdy[i],
                exp_ready(m[i], i == 2 ? int'(v) : int'(v[3:0]), i == 2 ? int'(sel) : int'(sel[1:0]), ordy, rst));
            m[i] = step(m[i], i == 2 ? int'(v) : int'(v[3:0]), i == 2 ? int'(sel) : int'(sel[1:0]), ordy, rst, dat, lst);
        end
    end

    int exp3[6] = '{0, 1, 2, 3, 0, 1};
`ifdef MUX_LAST_LOCK_EN
    int exp6[4] = '{0, 0, 0, 1};
`else
    int exp6[4] = '{0, 1, 0, 1};
`endif
    int cnt0;

    initial begin
        m[0] = '{n: 4, mode: 0, default: 0};
        m[1] = '{n: 4, mode: 1, default: 0};
        m[2] = '{n: 5, mode: 0, default: 0};
        rst = 1'b1; v = 5'h1f; lst = 5'h1f; sel = 3'd0; ordy = 1'b1;
        dat = 40'h44_33_A5_22_11;
        tick; tick;
        chk("reset_out_valid", int'(if0.out_valid), 0);
        chk("reset_out_data", int'(if0.out_data), 0);
        chk("reset_out_ch", int'(if1.out_ch), 0);
        chk("reset_in_ready", int'(if1.in_ready), 0);
        rst = 1'b0; sel = 3'd2;
        #1 chk("sel2_in_ready", int'(if0.in_ready), 4);
        tick;
        chk("sel2_out_valid", int'(if0.out_valid), 1);
        chk("sel2_out_data", int'(if0.out_data), 8'hA5);
        chk("sel2_out_ch", int'(if0.out_ch), 2);
        sel = 3'd5;
        #1 chk("sel5_in_ready_n5", int'(if5.in_ready), 0);
        sel = 3'd4;
        #1 chk("sel4_in_ready_n5", int'(if5.in_ready), 16);
        rst = 1'b1; tick; rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick;
            chk($sformatf("rr_seq%0d", k), int'(if1.out_ch), exp3[k]);
        end
        rst = 1'b1; tick; rst = 1'b0; v = 5'b00010; tick;
        v = 5'b01010; tick;
        chk("rr_wrap_first", int'(if1.out_ch), 3);
        tick;
        chk("rr_wrap_second", int'(if1.out_ch), 1);
        #1 chk("rr_ptr_ends_2", int'(if1.in_ready), 8);
        v = 5'h1f; sel = 3'd0; dat = 40'h00_33_00_00_11; tick;
        chk("bp_load_data", int'(if0.out_data), 8'h11);
        ordy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sel = 3'(k + 1);
            tick;
            chk("bp_hold_data", int'(if0.out_data), 8'h11);
            chk("bp_hold_ch", int'(if0.out_ch), 0);
            chk("bp_hold_valid", int'(if0.out_valid), 1);
            chk("bp_in_ready", int'(if0.in_ready), 0);
        end
        ordy = 1'b1; sel = 3'd3;
        #1 chk("bp_release_ready", int'(if0.in_ready), 8);
        tick;
        chk("bp_new_ch", int'(if0.out_ch), 3);
        chk("bp_new_data", int'(if0.out_data), 8'h33);
        rst = 1'b1; tick; rst = 1'b0; v = 5'b00011; cnt0 = 0;
        for (int k = 0; k < 4; k++) begin
            lst = {4'b1111, cnt0 == 2};
            #1 if (if1.in_ready[0]) cnt0++;
            tick;
            chk($sformatf("pkt_seq%0d", k), int'(if1.out_ch), exp6[k]);
        end
        rst = 1'b1; tick; rst = 1'b0; v = 5'b00001; lst = 5'b11110; tick;
        rst = 1'b1; tick; rst = 1'b0; v = 5'b00011;
        #1 chk("midpkt_rst_ptr0", int'(if1.in_ready), 1);
        v = 5'b00010;
        #1 chk("midpkt_rst_unlock", int'(if1.in_ready), 2);
        tick;
        for (int k = 0; k < 3000; k++) begin
            rst = $urandom_range(99) == 0;
            v = 5'($urandom);
            lst = 5'($urandom);
            sel = 3'($urandom);
            ordy = $urandom_range(3) != 0;
            dat = 40'({$urandom, $urandom});
            tick;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
